// File: rtl/br_defs.sv
// ----------------------------------------------------------------------------
// br_defs
// Shared definitions for branch resolution in the ID stage.
//   - br_type_e  : 3-bit branch codes, identical to the ones the decoder emits.
//   - br_state_e : 2-bit encodings for the branch_ctrl sequencer.
//   - br_needs   : which comparator operands a branch type depends on.
//   - br_eval    : branch outcome from the comparator flags.
// ----------------------------------------------------------------------------
package br_defs;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLEZ = 3'd2,
        BR_BGTZ = 3'd3,
        BR_BLTZ = 3'd4,
        BR_BGEZ = 3'd5,
        BR_J    = 3'd6,
        BR_RSVD = 3'd7
    } br_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_REDIR = 2'd2
    } br_state_e;

    // Returns {needs_rt, needs_rs}. Single-operand compares only look at rs;
    // jumps and the reserved code depend on nothing.
    function automatic logic [1:0] br_needs(input logic [2:0] br_code);
        logic [1:0] needs;
        needs = 2'b00;
        case (br_code)
            BR_BEQ, BR_BNE:                    needs = 2'b11;
            BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ: needs = 2'b01;
            default:                           needs = 2'b00;
        endcase
        return needs;
    endfunction

    // The reserved code is never taken; J is always taken.
    function automatic logic br_eval(input logic [2:0] br_code,
                                     input logic eq,
                                     input logic ltz,
                                     input logic gtz,
                                     input logic ez);
        logic taken;
        taken = 1'b0;
        case (br_code)
            BR_BEQ:  taken = eq;
            BR_BNE:  taken = !eq;
            BR_BLEZ: taken = ltz | ez;
            BR_BGTZ: taken = gtz;
            BR_BLTZ: taken = ltz;
            BR_BGEZ: taken = gtz | ez;
            BR_J:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset
//   inc   - count up by one this cycle
//   clr   - force to zero; takes priority over inc
//   count - current value
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// ----------------------------------------------------------------------------
// branch_ctrl
// Sequences branch resolution in ID around the signed branch comparator:
// waits for forwarded operands (stalling ID), evaluates the comparator flags
// for the decoded branch type, and issues a PC redirect over valid/ready.
// Only one branch is in flight at a time.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   br_valid/type/target  - branch presented by the decoder
//   rs_ready, rt_ready    - comparator operands are valid
//   comp_eq/ltz/gtz/ez    - comparator flags
//   cnt_clr               - clear the statistics counters
//   redir_ready           - PC unit accepts the redirect
//   id_stall              - hold IF/ID (combinational)
//   redir_valid, redir_pc - registered redirect request
//   br_done/taken/err     - one-cycle resolution pulses
//   cnt_branch, cnt_taken - saturating statistics
// ----------------------------------------------------------------------------
module branch_ctrl
    import br_defs::*;
#(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    input  logic [2:0]       br_type,
    input  logic [31:0]      br_target,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic             comp_eq,
    input  logic             comp_ltz,
    input  logic             comp_gtz,
    input  logic             comp_ez,
    input  logic             cnt_clr,
    input  logic             redir_ready,
    output logic             id_stall,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    output logic             br_done,
    output logic             br_taken,
    output logic             br_err,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken
);

    localparam int WC_W = $clog2(WAIT_MAX + 1);

    br_state_e       state;
    br_state_e       state_nx;
    logic [2:0]      lat_type;
    logic [31:0]     lat_target;
    logic [WC_W-1:0] wait_cnt;

    logic [2:0]      cur_type;
    logic [31:0]     cur_target;
    logic [1:0]      needs;
    logic            ops_ready;
    logic            taken;
    logic            resolve;
    logic            timeout;
    logic            start_wait;

    // While waiting, the decoder may already show the next instruction, so
    // the branch being resolved comes from the latched copy.
    assign cur_type   = (state == ST_WAIT) ? lat_type   : br_type;
    assign cur_target = (state == ST_WAIT) ? lat_target : br_target;
    assign needs      = br_needs(cur_type);
    assign ops_ready  = (!needs[0] || rs_ready) && (!needs[1] || rt_ready);
    assign taken      = br_eval(cur_type, comp_eq, comp_ltz, comp_gtz, comp_ez);

    always_comb begin
        state_nx   = state;
        resolve    = 1'b0;
        timeout    = 1'b0;
        start_wait = 1'b0;
        id_stall   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (br_valid) begin
                    if (ops_ready) begin
                        resolve  = 1'b1;
                        state_nx = taken ? ST_REDIR : ST_IDLE;
                    end else begin
                        start_wait = 1'b1;
                        id_stall   = 1'b1;
                        state_nx   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Stall holds through the resolving cycle so the delay-slot
                // instruction is not fetched past the branch early.
                id_stall = 1'b1;
                if (ops_ready) begin
                    resolve  = 1'b1;
                    state_nx = taken ? ST_REDIR : ST_IDLE;
                end else if (wait_cnt == WC_W'(WAIT_MAX)) begin
                    timeout  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_REDIR: begin
                id_stall = !redir_ready;
                if (redir_valid && redir_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            lat_type    <= '0;
            lat_target  <= '0;
            wait_cnt    <= '0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            br_done     <= 1'b0;
            br_taken    <= 1'b0;
            br_err      <= 1'b0;
        end else begin
            state    <= state_nx;
            br_done  <= resolve || timeout;
            br_taken <= resolve && taken;
            br_err   <= timeout || (resolve && (cur_type == BR_RSVD));

            if (start_wait) begin
                lat_type   <= br_type;
                lat_target <= br_target;
                wait_cnt   <= WC_W'(1);
            end else if (state == ST_WAIT) begin
                wait_cnt <= (state_nx == ST_WAIT) ? wait_cnt + 1'b1 : '0;
            end

            if (resolve && taken) begin
                redir_valid <= 1'b1;
                redir_pc    <= cur_target;
            end else if ((state == ST_REDIR) && redir_ready) begin
                redir_valid <= 1'b0;
            end
        end
    end

    // Timeouts are not resolutions and are not counted.
    sat_counter #(.WIDTH(CNT_W)) u_cnt_branch (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (resolve),
        .clr   (cnt_clr),
        .count (cnt_branch)
    );

    sat_counter #(.WIDTH(CNT_W)) u_cnt_taken (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (resolve && taken),
        .clr   (cnt_clr),
        .count (cnt_taken)
    );

endmodule

// File: tb/tb_branch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_branch_ctrl
// Scoreboard bench for branch_ctrl. The driver works at branch level: it picks
// real signed operand values, derives the comparator flags from them, decides
// how many cycles the operands stay unavailable and how long the PC unit
// withholds ready, and pushes the expected resolution / redirect into queues.
// A separate monitor pops and compares whenever the DUT pulses br_done or
// raises redir_valid.
// ----------------------------------------------------------------------------
module tb_branch_ctrl;

    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 8;
    localparam int MAXC     = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             br_valid;
    logic [2:0]       br_type;
    logic [31:0]      br_target;
    logic             rs_ready;
    logic             rt_ready;
    logic             comp_eq;
    logic             comp_ltz;
    logic             comp_gtz;
    logic             comp_ez;
    logic             cnt_clr;
    logic             redir_ready;
    logic             id_stall;
    logic             redir_valid;
    logic [31:0]      redir_pc;
    logic             br_done;
    logic             br_taken;
    logic             br_err;
    logic [CNT_W-1:0] cnt_branch;
    logic [CNT_W-1:0] cnt_taken;

    branch_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .br_valid    (br_valid),
        .br_type     (br_type),
        .br_target   (br_target),
        .rs_ready    (rs_ready),
        .rt_ready    (rt_ready),
        .comp_eq     (comp_eq),
        .comp_ltz    (comp_ltz),
        .comp_gtz    (comp_gtz),
        .comp_ez     (comp_ez),
        .cnt_clr     (cnt_clr),
        .redir_ready (redir_ready),
        .id_stall    (id_stall),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .br_done     (br_done),
        .br_taken    (br_taken),
        .br_err      (br_err),
        .cnt_branch  (cnt_branch),
        .cnt_taken   (cnt_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic taken;
        logic err;
        int   nb;
        int   nt;
    } done_t;

    typedef struct {
        logic [31:0] pc;
        int          len;
    } redir_t;

    done_t  done_q[$];
    redir_t redir_q[$];
    int     checks = 0;
    int     errors = 0;
    int     model_nb = 0;
    int     model_nt = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int x);
        return (x >= MAXC) ? MAXC : x + 1;
    endfunction

    // Branch outcome straight from the operand values.
    function automatic logic ref_taken(input int t, input int d1, input int d2);
        case (t)
            0:       return d1 == d2;
            1:       return d1 != d2;
            2:       return d1 <= 0;
            3:       return d1 > 0;
            4:       return d1 < 0;
            5:       return d1 >= 0;
            6:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // mode 0: never clear, 1: clear exactly on the resolving cycle, 2: sparse random
    function automatic logic pick_clr(input int mode, input logic is_resolve);
        if (mode == 1) return is_resolve;
        if (mode == 2) return ($urandom_range(0, 15) == 0);
        return 1'b0;
    endfunction

    // One cycle of stimulus. ev: 0 nothing resolves, 1 resolution, 2 timeout.
    task automatic applyStimulus(input logic v, input logic [2:0] ty, input logic [31:0] tg,
                                 input logic rs, input logic rt, input int d1, input int d2,
                                 input logic rr, input logic clr, input logic exp_stall,
                                 input int ev, input logic tk, input logic er,
                                 input logic [31:0] pc, input int rlen);
        done_t  d;
        redir_t r;
        @(negedge clk);
        br_valid    = v;
        br_type     = ty;
        br_target   = tg;
        rs_ready    = rs;
        rt_ready    = rt;
        comp_eq     = (d1 == d2);
        comp_ltz    = (d1 < 0);
        comp_gtz    = (d1 > 0);
        comp_ez     = (d1 == 0);
        redir_ready = rr;
        cnt_clr     = clr;
        #1 checkOutput("id_stall", 32'(id_stall), 32'(exp_stall));
        if (clr) begin
            model_nb = 0;
            model_nt = 0;
        end else if (ev == 1) begin
            model_nb = sat_inc(model_nb);
            if (tk) model_nt = sat_inc(model_nt);
        end
        if (ev == 1) begin
            d.taken = tk; d.err = er; d.nb = model_nb; d.nt = model_nt;
            done_q.push_back(d);
            if (tk) begin
                r.pc = pc; r.len = rlen;
                redir_q.push_back(r);
            end
        end else if (ev == 2) begin
            d.taken = 1'b0; d.err = 1'b1; d.nb = model_nb; d.nt = model_nt;
            done_q.push_back(d);
        end
    endtask

    task automatic idle_cycle(input int clr_mode);
        applyStimulus(1'b0, 3'($urandom_range(0, 7)), $urandom, 1'($urandom), 1'($urandom),
                      0, 1, 1'($urandom), pick_clr(clr_mode, 1'b0), 1'b0, 0, 1'b0, 1'b0, 32'h0, 0);
    endtask

    // k: cycles the needed operands stay unavailable; r: cycles redir_ready stays low.
    task automatic run_branch(input int t, input logic [31:0] tgt, input int d1, input int d2,
                              input int k, input int r, input int clr_mode);
        logic need_rs, need_rt, tk, er, tmo, ready, rs, rt, v, clr;
        logic [2:0]  ty;
        logic [31:0] tg;
        logic [1:0]  low;
        int keff, last, ev;
        need_rs = (t <= 5);
        need_rt = (t <= 1);
        tk      = ref_taken(t, d1, d2);
        er      = (t == 7);
        keff    = (t >= 6) ? 0 : k;
        tmo     = (keff > WAIT_MAX);
        last    = tmo ? WAIT_MAX : keff;
        for (int i = 0; i <= last; i++) begin
            ready = (i >= keff);
            if (ready) begin
                rs = need_rs ? 1'b1 : 1'($urandom);
                rt = need_rt ? 1'b1 : 1'($urandom);
            end else if (need_rt) begin
                low = 2'($urandom_range(1, 3));
                rs  = !low[0];
                rt  = !low[1];
            end else begin
                rs = 1'b0;
                rt = 1'($urandom);
            end
            if (i == 0) begin
                v = 1'b1; ty = 3'(t); tg = tgt;
            end else begin
                v = 1'($urandom); ty = 3'($urandom_range(0, 7)); tg = $urandom;
            end
            ev  = (i == last) ? (tmo ? 2 : 1) : 0;
            clr = pick_clr(clr_mode, ev == 1);
            applyStimulus(v, ty, tg, rs, rt, d1, d2, 1'($urandom), clr,
                          (i < keff) || (i > 0), ev, tk, er, tgt, r + 1);
        end
        if (!tmo && tk) begin
            for (int j = 0; j <= r; j++) begin
                applyStimulus(1'($urandom), 3'($urandom_range(0, 7)), $urandom, 1'($urandom),
                              1'($urandom), d1, d2, (j == r), pick_clr(clr_mode, 1'b0),
                              (j != r), 0, 1'b0, 1'b0, 32'h0, 0);
            end
        end
    endtask

    // Monitor: pops expectations whenever the DUT reports a resolution or a redirect.
    initial begin : monitor
        done_t  e;
        redir_t cur;
        logic   in_run;
        int     run_len;
        in_run  = 1'b0;
        run_len = 0;
        cur.pc  = '0;
        cur.len = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                in_run = 1'b0;
            end else begin
                if (br_done) begin
                    if (done_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_br_done: got br_done=1, expected no resolution at %0t", $time);
                    end else begin
                        e = done_q.pop_front();
                        checkOutput("br_taken", 32'(br_taken), 32'(e.taken));
                        checkOutput("br_err", 32'(br_err), 32'(e.err));
                        checkOutput("cnt_branch", 32'(cnt_branch), 32'(e.nb));
                        checkOutput("cnt_taken", 32'(cnt_taken), 32'(e.nt));
                    end
                end else begin
                    checkOutput("br_taken_quiet", 32'(br_taken), 32'h0);
                    checkOutput("br_err_quiet", 32'(br_err), 32'h0);
                end
                if (redir_valid) begin
                    if (!in_run) begin
                        if (redir_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpected_redir: got redir_valid=1 pc=0x%0h, expected none at %0t",
                                     redir_pc, $time);
                        end else begin
                            cur = redir_q.pop_front();
                            checkOutput("redir_pc", redir_pc, cur.pc);
                        end
                        in_run  = 1'b1;
                        run_len = 1;
                    end else begin
                        run_len++;
                        checkOutput("redir_pc_hold", redir_pc, cur.pc);
                    end
                end else if (in_run) begin
                    checkOutput("redir_len", 32'(run_len), 32'(cur.len));
                    in_run = 1'b0;
                end
            end
        end
    end

    initial begin : driver
        int t, d1, d2, k, r, gap, sel;
        rst_n = 1'b0; br_valid = 1'b0; br_type = '0; br_target = '0;
        rs_ready = 1'b0; rt_ready = 1'b0; comp_eq = 1'b0; comp_ltz = 1'b0;
        comp_gtz = 1'b0; comp_ez = 1'b0; cnt_clr = 1'b0; redir_ready = 1'b0;

        // Reset held with a resolvable taken BEQ presented.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            br_valid = 1'b1; br_type = 3'd0; br_target = 32'h0040_0100;
            rs_ready = 1'b1; rt_ready = 1'b1; comp_eq = 1'b1; redir_ready = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("rst_redir_valid", 32'(redir_valid), 32'h0);
            checkOutput("rst_redir_pc", redir_pc, 32'h0);
            checkOutput("rst_br_done", 32'(br_done), 32'h0);
            checkOutput("rst_br_taken", 32'(br_taken), 32'h0);
            checkOutput("rst_br_err", 32'(br_err), 32'h0);
            checkOutput("rst_cnt_branch", 32'(cnt_branch), 32'h0);
            checkOutput("rst_cnt_taken", 32'(cnt_taken), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1; br_valid = 1'b0;

        // Taken BEQ, PC unit busy for 3 cycles.
        run_branch(0, 32'h0040_0100, 5, 5, 0, 3, 0);
        // Back-to-back not-taken BNE then BGTZ.
        run_branch(1, 32'h0000_1000, 7, 7, 0, 0, 0);
        run_branch(3, 32'h0000_2000, -3, 4, 0, 0, 0);
        // BLEZ waiting two cycles on rs; target on the bus changes meanwhile.
        run_branch(2, 32'h0000_3000, 0, 9, 2, 1, 0);
        // BEQ that never gets rt, then the reserved code.
        run_branch(0, 32'h0000_4000, 1, 1, WAIT_MAX + 1, 0, 0);
        run_branch(7, 32'h0000_5000, 0, 0, 0, 0, 0);
        // Saturation, then clear coinciding with a taken branch.
        for (int i = 0; i < 17; i++) run_branch(6, 32'h0000_6000 + 32'(i), 0, 0, 0, 0, 0);
        run_branch(6, 32'h0000_7000, 0, 0, 0, 0, 1);
        idle_cycle(0);

        // Reset in the middle of an operand wait drops the branch silently.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 3'd0, 32'h0000_8000, 1'b0, 1'b1, 2, 2, 1'b1, 1'b0,
                          1'b1, 0, 1'b0, 1'b0, 32'h0, 0);
        end
        @(negedge clk);
        rst_n = 1'b0; br_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_nb = 0;
        model_nt = 0;
        idle_cycle(0);
        idle_cycle(0);
        checkOutput("post_rst_cnt_branch", 32'(cnt_branch), 32'h0);
        checkOutput("post_rst_redir_valid", 32'(redir_valid), 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            t   = int'($urandom_range(0, 7));
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       d1 = 0;
                1:       d1 = int'($urandom_range(0, 20)) - 10;
                2:       d1 = int'($urandom);
                default: d1 = -1;
            endcase
            d2  = ($urandom_range(0, 1) == 1) ? d1 : int'($urandom_range(0, 20)) - 10;
            k   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(WAIT_MAX - 1, WAIT_MAX + 2))
                                              : int'($urandom_range(0, 2));
            r   = int'($urandom_range(0, 3));
            run_branch(t, $urandom, d1, d2, k, r, 2);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) idle_cycle(2);
        end

        for (int i = 0; i < 4; i++) idle_cycle(0);
        checkOutput("done_q_drained", 32'(done_q.size()), 32'h0);
        checkOutput("redir_q_drained", 32'(redir_q.size()), 32'h0);
        checkOutput("final_cnt_branch", 32'(cnt_branch), 32'(model_nb));
        checkOutput("final_cnt_taken", 32'(cnt_taken), 32'(model_nt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequences branch resolution in the ID stage around the 32-bit signed branch comparator.
- Waits for forwarded operands, stalling ID while it waits.
- Evaluates comparator flags against the decoded branch type, then issues a PC redirect using a valid/ready handshake.
- Keeps saturating branch/taken statistics; one branch outstanding at a time.

Parameters:
- CNT_W, 16, width of statistics counters
- WAIT_MAX, 8, max cycles in WAIT before operand-timeout abort (must be >=1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- br_valid  in  1  branch instruction present in ID
- br_type  in  3  branch code (see Behaviour)
- br_target  in  32  branch target PC
- rs_ready  in  1  rs operand valid at comparator D1
- rt_ready  in  1  rt operand valid at comparator D2
- comp_eq  in  1  D1 == D2
- comp_ltz  in  1  D1 < 0 (signed)
- comp_gtz  in  1  D1 > 0 (signed)
- comp_ez  in  1  D1 == 0
- cnt_clr  in  1  clear both statistics counters
- redir_ready  in  1  PC unit accepts redirect
- id_stall  out  1  hold IF/ID (combinational)
- redir_valid  out  1  redirect request (registered)
- redir_pc  out  32  redirect target (registered)
- br_done  out  1  one-cycle pulse: branch resolved
- br_taken  out  1  qualifies br_done
- br_err  out  1  one-cycle pulse: timeout or reserved type
- cnt_branch  out  CNT_W  resolved branches, saturating
- cnt_taken  out  CNT_W  taken branches, saturating

Behaviour:
- Types and their needs:
  - 0 BEQ: taken on eq; needs rs, rt.
  - 1 BNE: taken on !eq; needs rs, rt.
  - 2 BLEZ: taken on ltz|ez; needs rs.
  - 3 BGTZ: taken on gtz; needs rs.
  - 4 BLTZ: taken on ltz; needs rs.
  - 5 BGEZ: taken on gtz|ez; needs rs.
  - 6 J: always taken; needs nothing.
  - 7 reserved: not taken, needs nothing, br_err pulses with br_done.
- ops_ready = required readies all high.
- Reset (rst_n low at edge):
  - State IDLE.
  - redir_valid=0, redir_pc=0, br_done=0, br_taken=0, br_err=0, counters=0, wait counter=0.
  - Reset mid-REDIR or mid-WAIT drops the pending branch with no pulse.
- FSM states: IDLE, WAIT, REDIR.
- IDLE, br_valid & ops_ready:
  - Resolve this edge; next cycle br_done=1, br_taken=T.
  - If T: redir_valid=1, redir_pc=br_target, go to REDIR; else stay IDLE.
- IDLE, br_valid & !ops_ready:
  - Latch br_type/br_target, wait counter=1, go to WAIT.
- WAIT:
  - Uses the latched type and target; br_valid is ignored.
  - When ops_ready: resolve as in IDLE.
  - Else, when wait counter == WAIT_MAX: br_err and br_done pulse with br_taken=0, go to IDLE, no counter increment.
  - Else increment the wait counter.
- REDIR:
  - redir_valid and redir_pc held stable until redir_valid & redir_ready, then go to IDLE; redir_valid=0 next cycle.
  - br_valid is ignored.
- Latency: resolution to br_done/redir_valid is 1 cycle.
- Throughput: not-taken branches back-to-back, one per cycle.
- Stall and delay slot:
  - id_stall = (IDLE & br_valid & !ops_ready) | WAIT | (REDIR & !redir_ready).
  - The delay slot is not flushed; this block issues no flush.
- Counters:
  - cnt_branch += 1 on every non-timeout resolution, type 7 included.
  - cnt_taken += 1 when T.
  - Both saturate at all-ones.
  - cnt_clr wins over a same-cycle increment, so the value is 0.
- br_done, br_taken and br_err are zero in all cycles not listed above.

Decomposition:
- Shared include/package br_defs: BR_BEQ..BR_RSVD 3-bit codes and FSM state encodings (2-bit). The decoder uses the same codes.
- One sub-module, sat_counter (WIDTH param; inc, clr, synchronous active-low reset), instantiated twice for the statistics.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 for 2 cycles with br_valid=1, type BEQ, comp_eq=1.
  - Response: all outputs 0, counters 0; after release, first resolution one cycle later.
- BEQ taken with handshake:
  - Stimulus: BEQ, both ready, comp_eq=1, br_target=0x0040_0100; redir_ready low 3 cycles then high.
  - Response: br_done=1, br_taken=1 next cycle; redir_valid/redir_pc=0x0040_0100 held 4 cycles; id_stall high 3 cycles; cnt_taken=1.
- Back-to-back not taken:
  - Stimulus: BNE with comp_eq=1, then BGTZ with gtz=0, on consecutive cycles, operands ready.
  - Response: two consecutive br_done pulses, br_taken=0, no redir_valid, cnt_branch=2.
- Operand wait:
  - Stimulus: BLEZ, rs_ready low 2 cycles, then high with comp_ez=1.
  - Response: id_stall 3 cycles, br_taken=1, redir_pc equals the target latched on the first cycle even if br_target changes.
- Timeout and reserved type:
  - Stimulus: BEQ with rt_ready never high (WAIT_MAX=8); then type 7.
  - Response: br_err and br_done pulse, br_taken=0, counters unchanged; then type 7 gives br_err, br_taken=0, cnt_branch+1.
- Saturation and clear:
  - Stimulus: CNT_W=4, 17 taken J branches; then cnt_clr together with a taken branch.
  - Response: counters stick at 15; clear yields 0 that cycle.
